// File: rtl/instr_prefetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_prefetch_unit_if
//
// Groups the two handshakes of the instruction prefetch unit:
//   * memory side : mem_req/mem_addr out to instruction memory,
//                   mem_ack/mem_rdata back from it (request/acknowledge,
//                   wait states allowed, ack may arrive in the request's
//                   first cycle)
//   * core side   : instr_valid/instr/instr_pc out to the core,
//                   instr_ready back from it (valid/ready)
//
// Modports:
//   master - the prefetch unit (drives requests and the instruction stream)
//   slave  - the environment (instruction memory plus consuming core)
// ---------------------------------------------------------------------------
interface instr_prefetch_unit_if;

   // Memory read channel
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   // Instruction delivery channel
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata,
      output instr_valid,
      input  instr_ready,
      output instr,
      output instr_pc
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata,
      input  instr_valid,
      output instr_ready,
      input  instr,
      input  instr_pc
   );

endinterface

// File: rtl/instr_prefetch_unit.sv
// ---------------------------------------------------------------------------
// instr_prefetch_unit
//
// Fetch front-end for the single-cycle MIPS core. Holds the fetch PC, reads
// instruction words from memory one request at a time, buffers each word
// with its PC in a small FIFO and hands them to the core over valid/ready.
// A redirect (taken branch) flushes the FIFO and restarts fetch at the
// branch target; a read that was already in flight is let complete and its
// data thrown away.
//
// Parameters:
//   DEPTH    - FIFO entries (power of two, at least 2)
//   RESET_PC - first fetch address after reset
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   reset       - asynchronous, active-low reset (0 = in reset)
//   redirect    - flush and restart fetch at redirect_pc
//   redirect_pc - new fetch address, low two bits ignored
//   fifo_count  - current FIFO occupancy
//   bus         - memory request/ack channel and instruction valid/ready
//                 channel (master side)
// ---------------------------------------------------------------------------
module instr_prefetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         redirect,
   input  logic [31:0]                  redirect_pc,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   instr_prefetch_unit_if.master        bus
);

   localparam int             CW      = $clog2(DEPTH + 1);
   localparam int             PW      = $clog2(DEPTH);
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   // IDLE: nothing outstanding. WAIT: a read is outstanding and its data is
   // wanted. DISCARD: a read is outstanding but a redirect made it stale.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DISCARD
   } state_t;

   state_t         state;
   state_t         state_next;

   logic [31:0]    fetch_pc;
   logic [31:0]    fetch_pc_next;
   logic [31:0]    req_addr;
   logic [31:0]    req_addr_next;

   logic [31:0]    data_mem [DEPTH];
   logic [31:0]    pc_mem   [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic [CW-1:0]  count_next;

   logic           push;
   logic           pop;
   logic           flush;
   logic           has_room;
   logic [31:0]    redirect_base;
   logic [31:0]    discard_target;

   // The branch target is always word aligned; the low bits of redirect_pc
   // are simply cleared rather than trusted.
   assign redirect_base = redirect_pc & 32'hFFFF_FFFC;

   // A word is written into the FIFO only when a wanted read completes and
   // no redirect arrives in the same cycle (a redirect makes that word
   // stale). The core pops whenever the head is valid and it is ready.
   assign push = (state == ST_WAIT) && bus.mem_ack && !redirect;
   assign pop  = (count != '0) && bus.instr_ready;

   // Occupancy after this cycle's push/pop. A new request is only launched
   // while this is below DEPTH, which keeps one slot reserved for every
   // outstanding read so the FIFO can never overflow.
   assign count_next = count + CW'(push) - CW'(pop);
   assign has_room   = (count_next < DEPTH_C);

   // Any redirect empties the buffer, whatever state the fetch engine is in.
   assign flush = redirect;

   // State register plus the two address registers that follow the FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         req_addr <= req_addr_next;
      end
   end

   // Next-state logic. The decisions are ordered so a redirect always wins
   // over a normal completion. In WAIT a redirect without an ack leaves the
   // old request on the bus (the memory must see a stable address until it
   // acks), so only fetch_pc moves and the engine parks in DISCARD until
   // the stale word arrives. In DISCARD a further redirect just replaces
   // the target, and when the stale ack finally lands the target request
   // goes out in the very next cycle.
   always_comb begin
      state_next     = state;
      fetch_pc_next  = fetch_pc;
      req_addr_next  = req_addr;
      discard_target = redirect ? redirect_base : fetch_pc;

      case (state)
         ST_IDLE: begin
            if (redirect) begin
               req_addr_next = redirect_base;
               fetch_pc_next = redirect_base + 32'd4;
               state_next    = ST_WAIT;
            end else if (has_room) begin
               req_addr_next = fetch_pc;
               fetch_pc_next = fetch_pc + 32'd4;
               state_next    = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (redirect && bus.mem_ack) begin
               req_addr_next = redirect_base;
               fetch_pc_next = redirect_base + 32'd4;
               state_next    = ST_WAIT;
            end else if (redirect) begin
               fetch_pc_next = redirect_base;
               state_next    = ST_DISCARD;
            end else if (bus.mem_ack) begin
               if (has_room) begin
                  req_addr_next = fetch_pc;
                  fetch_pc_next = fetch_pc + 32'd4;
                  state_next    = ST_WAIT;
               end else begin
                  state_next    = ST_IDLE;
               end
            end
         end

         ST_DISCARD: begin
            if (bus.mem_ack) begin
               req_addr_next = discard_target;
               fetch_pc_next = discard_target + 32'd4;
               state_next    = ST_WAIT;
            end else begin
               fetch_pc_next = discard_target;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // FIFO storage, pointers and occupancy. A flush wins over push and pop:
   // a pop in the redirect cycle still counts as consumed by the core, and
   // the buffer is empty afterwards either way. Storage is cleared on reset
   // so the head outputs read zero until the first word lands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            data_mem[wr_ptr] <= bus.mem_rdata;
            pc_mem[wr_ptr]   <= req_addr;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count_next;
      end
   end

   // Everything presented to memory and to the core comes straight from
   // registers, so there is no combinational path from any input.
   assign bus.mem_req     = (state != ST_IDLE);
   assign bus.mem_addr    = req_addr;
   assign bus.instr_valid = (count != '0);
   assign bus.instr       = data_mem[rd_ptr];
   assign bus.instr_pc    = pc_mem[rd_ptr];
   assign fifo_count      = count;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_prefetch_unit
//
// Bench for instr_prefetch_unit. dut_a runs against a memory model with a
// configurable number of wait states (fixed or random); dut_b uses
// RESET_PC = FFFF_FFF8 with a zero-wait memory and an always-ready core to
// show PC wrap-around. Memory returns addr ^ A5A5_A5A5 for every word.
// ---------------------------------------------------------------------------
module tb_instr_prefetch_unit;

   localparam logic [31:0] KEY      = 32'hA5A5_A5A5;
   localparam logic [31:0] RESET_B  = 32'hFFFF_FFF8;

   logic        clk;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [2:0]  fifo_count_a;
   logic [2:0]  fifo_count_b;

   int total;
   int bad;
   int fixed_wait;
   int wait_left;

   instr_prefetch_unit_if bus_a ();
   instr_prefetch_unit_if bus_b ();

   instr_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fifo_count  (fifo_count_a),
      .bus         (bus_a)
   );

   instr_prefetch_unit #(.DEPTH(4), .RESET_PC(RESET_B)) dut_b (
      .clk         (clk),
      .reset       (reset),
      .redirect    (1'b0),
      .redirect_pc (32'h0000_0000),
      .fifo_count  (fifo_count_b),
      .bus         (bus_b)
   );

   // Clock: 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory for dut_a: decides the ack for the current cycle at the falling
   // edge. wait_left counts the wait cycles still to go for the current
   // request; a fresh count is drawn every time an ack is given.
   assign bus_a.mem_rdata = bus_a.mem_addr ^ KEY;
   always @(negedge clk) begin
      if (bus_a.mem_req) begin
         if (wait_left <= 0) begin
            bus_a.mem_ack = 1'b1;
            wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
         end else begin
            bus_a.mem_ack = 1'b0;
            wait_left = wait_left - 1;
         end
      end else begin
         bus_a.mem_ack = 1'b0;
      end
   end

   // Zero-wait memory and always-ready core for dut_b
   assign bus_b.mem_ack     = bus_b.mem_req;
   assign bus_b.mem_rdata   = bus_b.mem_addr ^ KEY;
   assign bus_b.instr_ready = 1'b1;

   // One directed-table row: inputs for the cycle and the outputs expected
   // during it.
   typedef struct {
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [2:0]  exp_count;
   } vec_t;

   vec_t vecs [18];

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic rdy, input logic rd, input logic [31:0] rp);
      bus_a.instr_ready = rdy;
      redirect          = rd;
      redirect_pc       = rp;
   endtask

   // Hold reset for two cycles, then release just after a falling edge so
   // the caller starts in "cycle 0" (first rising edge out of reset ahead).
   task automatic do_reset(input int fw);
      reset = 1'b0;
      apply_stimulus(1'b0, 1'b0, 32'h0);
      fixed_wait = fw;
      wait_left  = (fw > 0) ? fw : 0;
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   // Safety net so the run always ends
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] exp_b;
      logic        prev_pending;
      logic [31:0] prev_addr;
      logic        rdy;
      logic        rd;
      logic [31:0] rp;
      int          consumed;

      total = 0;
      bad   = 0;
      reset = 1'b0;
      apply_stimulus(1'b0, 1'b0, 32'h0);

      // ---- Directed table: fill to saturation, drain, redirect to 0x203 --
      vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   3'd0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   3'd0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   3'd1};
      vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0,   3'd2};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h0,   3'd3};
      for (int i = 5; i <= 9; i++)
         vecs[i] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h0,   3'd4};
      vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   3'd4};
      vecs[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h4,   3'd3};
      vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h8,   3'd3};
      vecs[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'hC,   3'd3};
      vecs[14] = '{1'b1, 1'b1, 32'h203, 1'b1, 32'h1C,  1'b1, 32'h10,  3'd3};
      vecs[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   3'd0};
      vecs[16] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200, 3'd1};
      vecs[17] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204, 3'd1};

      do_reset(0);
      for (int i = 0; i < 18; i++) begin
         check_output($sformatf("tbl%0d_req", i), 32'(bus_a.mem_req), 32'(vecs[i].exp_req));
         if (vecs[i].exp_req)
            check_output($sformatf("tbl%0d_addr", i), bus_a.mem_addr, vecs[i].exp_addr);
         check_output($sformatf("tbl%0d_valid", i), 32'(bus_a.instr_valid), 32'(vecs[i].exp_valid));
         check_output($sformatf("tbl%0d_count", i), 32'(fifo_count_a), 32'(vecs[i].exp_count));
         if (vecs[i].exp_valid) begin
            check_output($sformatf("tbl%0d_pc", i), bus_a.instr_pc, vecs[i].exp_pc);
            check_output($sformatf("tbl%0d_instr", i), bus_a.instr, vecs[i].exp_pc ^ KEY);
         end
         // dut_b: addresses FFFF_FFF8, FFFF_FFFC, 0, 4, ... wrap modulo 2^32
         if (i >= 1 && i <= 5) begin
            exp_b = RESET_B + 32'(4 * (i - 1));
            check_output($sformatf("wrap%0d_addr", i), bus_b.mem_addr, exp_b);
         end
         if (i >= 2 && i <= 5) begin
            exp_b = RESET_B + 32'(4 * (i - 2));
            check_output($sformatf("wrap%0d_pc", i), bus_b.instr_pc, exp_b);
            check_output($sformatf("wrap%0d_instr", i), bus_b.instr, exp_b ^ KEY);
            check_output($sformatf("wrap%0d_count", i), 32'(fifo_count_b), 32'd1);
         end
         apply_stimulus(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
         next_cycle();
      end

      // ---- 3-wait memory, redirect during the 0x8 request -----------------
      do_reset(3);
      bus_a.instr_ready = 1'b1;
      for (int k = 0; k < 40 && !(bus_a.mem_req && bus_a.mem_addr == 32'h8); k++)
         next_cycle();
      check_output("disc_reach8", bus_a.mem_addr, 32'h8);
      apply_stimulus(1'b1, 1'b1, 32'h100);
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         apply_stimulus(1'b1, 1'b0, 32'h0);
         check_output($sformatf("disc%0d_req", k), 32'(bus_a.mem_req), 32'd1);
         check_output($sformatf("disc%0d_addr", k), bus_a.mem_addr, 32'h8);
         check_output($sformatf("disc%0d_valid", k), 32'(bus_a.instr_valid), 32'd0);
      end
      next_cycle();
      check_output("disc_newaddr", bus_a.mem_addr, 32'h100);
      for (int k = 0; k < 20 && !bus_a.instr_valid; k++)
         next_cycle();
      check_output("disc_first_pc", bus_a.instr_pc, 32'h100);
      check_output("disc_first_instr", bus_a.instr, 32'h100 ^ KEY);

      // ---- Redirect to 0x203 with pop and ack at count 2 ------------------
      do_reset(0);
      for (int k = 0; k < 20 && fifo_count_a != 3'd2; k++)
         next_cycle();
      check_output("rc2_reach", 32'(fifo_count_a), 32'd2);
      apply_stimulus(1'b1, 1'b1, 32'h203);
      next_cycle();
      apply_stimulus(1'b1, 1'b0, 32'h0);
      check_output("rc2_count", 32'(fifo_count_a), 32'd0);
      check_output("rc2_valid", 32'(bus_a.instr_valid), 32'd0);
      check_output("rc2_addr", bus_a.mem_addr, 32'h200);
      next_cycle();
      check_output("rc2_valid2", 32'(bus_a.instr_valid), 32'd1);
      check_output("rc2_pc", bus_a.instr_pc, 32'h200);

      // ---- Async reset while waiting with three words buffered ------------
      do_reset(0);
      for (int k = 0; k < 20 && fifo_count_a != 3'd3; k++)
         next_cycle();
      check_output("ar_reach3", 32'(fifo_count_a), 32'd3);
      check_output("ar_req_before", 32'(bus_a.mem_req), 32'd1);
      reset = 1'b0;
      #1;
      check_output("ar_req", 32'(bus_a.mem_req), 32'd0);
      check_output("ar_addr", bus_a.mem_addr, 32'h0);
      check_output("ar_valid", 32'(bus_a.instr_valid), 32'd0);
      check_output("ar_count", 32'(fifo_count_a), 32'd0);
      check_output("ar_instr", bus_a.instr, 32'h0);
      check_output("ar_pc", bus_a.instr_pc, 32'h0);

      // ---- Random waits, ready and redirects against a program-order model
      // The core must see RESET_PC, +4, +8 ... and, after a redirect, the
      // aligned target, +4, ... ; a word popped in the redirect cycle still
      // belongs to the old stream.
      do_reset(-1);
      exp_pc       = 32'h0;
      prev_pending = 1'b0;
      prev_addr    = 32'h0;
      consumed     = 0;
      for (int c = 0; c < 3000; c++) begin
         if (prev_pending) begin
            check_output("rnd_hold_req", 32'(bus_a.mem_req), 32'd1);
            check_output("rnd_hold_addr", bus_a.mem_addr, prev_addr);
         end
         check_output("rnd_valid", 32'(bus_a.instr_valid), 32'(fifo_count_a != 3'd0));
         check_output("rnd_count_max", 32'(fifo_count_a <= 3'd4), 32'd1);
         rdy = ($urandom_range(0, 3) != 0);
         rd  = ($urandom_range(0, 15) == 0);
         rp  = $urandom();
         if (bus_a.instr_valid && rdy) begin
            check_output("rnd_pc", bus_a.instr_pc, exp_pc);
            check_output("rnd_instr", bus_a.instr, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (rd)
            exp_pc = rp & 32'hFFFF_FFFC;
         prev_pending = bus_a.mem_req && !bus_a.mem_ack;
         prev_addr    = bus_a.mem_addr;
         apply_stimulus(rdy, rd, rp);
         next_cycle();
      end
      check_output("rnd_progress", 32'(consumed > 500), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_prefetch_unit.md
# instr_prefetch_unit

Instruction fetch front-end that sits directly upstream of the single-cycle MIPS core. It holds the fetch PC and issues word reads to instruction memory over a request/acknowledge handshake tolerant of wait states. It buffers returned words with their PCs in a small FIFO and presents them to the core over a valid/ready interface. A redirect input from the core's branch logic flushes the buffer and restarts fetch at the branch target, discarding any in-flight stale read.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 = in reset
- mem_req  out  1  read request to instruction memory; held high until acknowledged
- mem_addr  out  32  word address of current request; stable while mem_req=1 and mem_ack=0
- mem_ack  in  1  one-cycle completion pulse; may assert in the same cycle mem_req rises (zero-wait)
- mem_rdata  in  32  read data; valid only when mem_ack=1
- redirect  in  1  flush and restart fetch (taken branch)
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0
- instr_valid  out  1  FIFO head valid (count != 0)
- instr_ready  in  1  core consumes head when instr_valid & instr_ready
- instr  out  32  instruction word at FIFO head
- instr_pc  out  32  PC of instr
- fifo_count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- State machine with three states: IDLE (no request outstanding), WAIT (request outstanding, data wanted), DISCARD (request outstanding, data stale).
- Registers: fetch_pc (next address to request), req_addr (drives mem_addr), FIFO storage, read/write pointers, count.
- mem_req = 1 in WAIT and DISCARD, 0 in IDLE.
- Decision rules, evaluated in priority order:
  - IDLE, redirect: flush FIFO; req_addr ← redirect_pc; fetch_pc ← redirect_pc+4; go to WAIT.
  - IDLE, count_next < DEPTH: req_addr ← fetch_pc; fetch_pc += 4; go to WAIT.
  - WAIT, redirect & mem_ack: drop data; flush; req_addr ← redirect_pc; fetch_pc ← redirect_pc+4; stay in WAIT.
  - WAIT, redirect & !mem_ack: flush; fetch_pc ← redirect_pc; go to DISCARD; mem_addr is held.
  - WAIT, mem_ack: push {req_addr, mem_rdata}. If count_next < DEPTH, req_addr ← fetch_pc, fetch_pc += 4, and stay in WAIT (back-to-back). Otherwise go to IDLE.
  - DISCARD, redirect: fetch_pc ← redirect_pc. Remain in DISCARD unless mem_ack, in which case apply the next rule.
  - DISCARD, mem_ack: drop data; req_addr ← fetch_pc; fetch_pc += 4; go to WAIT.
- count_next = count + push − pop, where pop = instr_valid & instr_ready.
- A request is issued only when count_next < DEPTH, so a slot is always reserved and the FIFO never overflows.
- A pop in a redirect cycle completes (the head was consumed); the flush then empties the FIFO, so count = 0 on the next cycle.
- Push and pop in the same cycle at count = DEPTH−1 or count = 1 are both legal and leave count unchanged.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: state IDLE; fetch_pc = RESET_PC; req_addr = RESET_PC; mem_req = 0; count = 0; instr_valid = 0; instr = 0; instr_pc = 0; pointers = 0.
- Assertion of reset mid-transaction aborts immediately. The memory must tolerate mem_req dropping without an ack.
- First cycle after reset release: mem_req = 1, mem_addr = RESET_PC.
- Zero-wait memory: data acked in cycle N appears as instr_valid in cycle N+1.
- Sustained throughput: 1 instruction/cycle with zero-wait memory and instr_ready held at 1.
- Redirect in cycle N: instr_valid = 0 in N+1. With zero-wait memory, the first redirected instruction is valid in N+2, or in N+3 if the redirect caught a request outstanding without ack (DISCARD).
- instr, instr_pc, instr_valid and fifo_count are driven from registers, with no combinational path from any input.

## Test plan
- Reset release, zero-wait memory returning addr^32'hA5A5_A5A5, instr_ready=1 -> mem_addr 0,4,8,… on consecutive cycles; instr_valid from cycle 2; instr_pc sequence 0,4,8 with matching data.
- instr_ready=0 for 10 cycles -> fifo_count saturates at 4; mem_req drops; no request for address 0x10 until one pop occurs; no data lost.
- 3-cycle wait-state memory with redirect to 0x100 in the first wait cycle of the 0x8 request -> mem_addr stays 0x8 until ack; that data is dropped; next request is 0x100; first delivered instr_pc is 0x100.
- Redirect to 0x203 coincident with a pop and an ack at count=2 -> FIFO empty next cycle; next request address is 0x200.
- Apply RESET_PC=32'hFFFF_FFF8 and let fetch run -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset while in WAIT with count=3 -> all outputs at their reset values immediately, without waiting for a clock edge.
